rc4_key_search_ctrl: RTL
========================

// Module: rc4_key_search_ctrl
// PURPOSE
//  Top-level scheduler for one RC4 cracking core. It steps a candidate key through
//  [KEY_FIRST..KEY_LAST] and runs, per key, the S-init, KSA and decryption sub-FSMs.
//  It owns the single-port S RAM mux and checks each decrypted byte as it is produced.
//  It aborts a key on the first non-text byte and reports the first key whose whole
//  message decodes to text.
// PARAMETERS
//  KEY_FIRST  22'h000000  first candidate key (key[23:22] always 2'b00)
//  KEY_LAST   22'h3FFFFF  last candidate key, inclusive
//  MSG_DEP    32          decrypted message length, bytes
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  start        in   1   one-cycle request to begin search; ignored while busy
//  init_start   out  1   one-cycle pulse: S[i]=i fill
//  init_done    in   1   one-cycle pulse from init FSM
//  ksa_start    out  1   one-cycle pulse: key-schedule swap loop
//  ksa_done     in   1   one-cycle pulse from KSA FSM
//  dec_start    out  1   one-cycle pulse: PRGA/decrypt
//  dec_abort    out  1   one-cycle pulse: stop decrypt, return to idle
//  dec_done     in   1   one-cycle pulse: decrypt finished or abort acknowledged
//  byte_valid   in   1   decrypted byte strobe
//  byte_data    in   8   decrypted byte
//  mem_owner    out  2   S RAM mux select: 0=init 1=ksa 2=dec 3=none
//  key          out  24  current candidate {2'b00, key[21:0]}
//  busy         out  1   search in progress
//  found        out  1   level: key holds the winning key
//  exhausted    out  1   level: KEY_LAST failed, no key found
// BEHAVIOUR
//  Reset (synchronous, active-high; clock clk):
//  - state IDLE; all pulses 0; mem_owner=3; key={2'b00,KEY_FIRST}; busy/found/exhausted=0.
//  - Reset mid-search abandons everything at once; no abort is issued.
//  Registered outputs; every *_start / dec_abort is high exactly one cycle, on state entry.
//  States:
//  - IDLE: start -> INIT_GO; key=KEY_FIRST; found/exhausted cleared; busy=1.
//  - INIT_GO (pulse init_start, owner=0) -> INIT_WAIT; init_done -> KSA_GO.
//  - KSA_GO (pulse ksa_start, owner=1) -> KSA_WAIT; ksa_done -> DEC_GO.
//  - DEC_GO (pulse dec_start, owner=2; clear bad flag and byte count) -> DEC_WAIT.
//  - DEC_WAIT byte check (per byte_valid):
//    - Text is 8'h61..8'h7A or 8'h20.
//    - A text byte increments byte count (6-bit).
//    - A non-text byte -> ABORT; dec_abort pulses on the next cycle.
//  - DEC_WAIT on dec_done:
//    - count==MSG_DEP and no bad byte -> FOUND.
//    - otherwise -> NEXT_KEY (short message = fail).
//  - Same-cycle events in DEC_WAIT: byte_valid and dec_done both high -> judge the byte
//    first, then apply the dec_done rule with it counted.
//  - ABORT: owner stays 2; wait dec_done; byte_valid ignored -> NEXT_KEY.
//  - NEXT_KEY: owner=3.
//    - key==KEY_LAST -> EXHAUSTED.
//    - else key+1 -> INIT_GO.
//    - No wrap-around past KEY_LAST.
//  - FOUND / EXHAUSTED: busy=0, owner=3, flag held, key frozen; start -> fresh search from KEY_FIRST.
//  Ignored inputs:
//  - *_done outside its matching WAIT/ABORT state.
//  - byte_valid outside DEC_WAIT.
//  - start while busy.
//  Min per-key overhead: 4 controller cycles (INIT_GO, KSA_GO, DEC_GO, NEXT_KEY) plus
//  sub-FSM latencies.
//  mem_owner changes only in *_GO/NEXT_KEY, never while a sub-FSM is active.
// TESTING
//  - reset, start; 32 bytes 8'h61 then dec_done -> found=1, key=24'h0, busy=0.
//  - 5th byte 8'h41 on key 0 -> dec_abort one pulse later; after dec_done: key=1,
//    init_start pulses, owner 3->0.
//  - KEY_FIRST=KEY_LAST=22'h5; bad byte -> exhausted=1, found=0, key=24'h5.
//  - dec_done after 31 text bytes -> fail, key increments.
//  - Same-cycle byte_valid=1 (8'h20, 32nd byte) with dec_done -> found=1.
//  - Reset asserted in KSA_WAIT -> next cycle all outputs at reset values.
//  - Stray ksa_done in INIT_WAIT -> no state change.

Source files
------------

// File: rtl/rc4_key_search_ctrl_if.sv
// Control bundle between the RC4 key-search scheduler and its sub-FSMs / S RAM mux.
// Handshake: every *_start, dec_abort and *_done is a single-cycle pulse with no back-pressure;
// byte_valid qualifies byte_data for exactly the cycle it is high.
interface rc4_key_search_ctrl_if;
  logic        start;
  logic        init_start;
  logic        init_done;
  logic        ksa_start;
  logic        ksa_done;
  logic        dec_start;
  logic        dec_abort;
  logic        dec_done;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [1:0]  mem_owner;
  logic [23:0] key;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [3:0]  dbg_state;

  modport slave (
    input  start, init_done, ksa_done, dec_done, byte_valid, byte_data,
    output init_start, ksa_start, dec_start, dec_abort, mem_owner, key,
           busy, found, exhausted, dbg_state
  );

  modport master (
    output start, init_done, ksa_done, dec_done, byte_valid, byte_data,
    input  init_start, ksa_start, dec_start, dec_abort, mem_owner, key,
           busy, found, exhausted, dbg_state
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Scheduler for one RC4 cracking core: walks candidate keys, sequences init/KSA/decrypt,
// owns the S RAM mux select and screens every decrypted byte for plain lowercase text.
module rc4_key_search_ctrl #(
  parameter logic [21:0] KEY_FIRST = 22'h000000,
  parameter logic [21:0] KEY_LAST  = 22'h3FFFFF,
  parameter int unsigned MSG_DEP   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  rc4_key_search_ctrl_if.slave        bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_GO   = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_KSA_GO    = 4'd3,
    ST_KSA_WAIT  = 4'd4,
    ST_DEC_GO    = 4'd5,
    ST_DEC_WAIT  = 4'd6,
    ST_ABORT     = 4'd7,
    ST_NEXT_KEY  = 4'd8,
    ST_FOUND     = 4'd9,
    ST_EXHAUSTED = 4'd10
  } state_e;

  localparam logic [1:0] OWN_INIT = 2'd0;
  localparam logic [1:0] OWN_KSA  = 2'd1;
  localparam logic [1:0] OWN_DEC  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;
  localparam logic [5:0] MSG_DEP_C = 6'(MSG_DEP);

  state_e      state_q, state_d;
  logic [21:0] key_q, key_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;

  logic        init_start_q, init_start_d;
  logic        ksa_start_q, ksa_start_d;
  logic        dec_start_q, dec_start_d;
  logic        dec_abort_q, dec_abort_d;
  logic [1:0]  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        found_q, found_d;
  logic        exhausted_q, exhausted_d;

  logic        is_text;
  logic [5:0]  cnt_seen;
  logic        bad_seen;

  always_comb begin
    is_text = (bus.byte_data == 8'h20) ||
              ((bus.byte_data >= 8'h61) && (bus.byte_data <= 8'h7A));
  end

  // Next state. A byte arriving together with dec_done is judged first and then counted
  // toward the end-of-message verdict.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    cnt_seen = cnt_q;
    bad_seen = bad_q;

    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (bus.start) begin
          state_d = ST_INIT_GO;
          key_d   = KEY_FIRST;
        end
      end

      ST_INIT_GO: state_d = ST_INIT_WAIT;

      ST_INIT_WAIT: begin
        if (bus.init_done) state_d = ST_KSA_GO;
      end

      ST_KSA_GO: state_d = ST_KSA_WAIT;

      ST_KSA_WAIT: begin
        if (bus.ksa_done) state_d = ST_DEC_GO;
      end

      ST_DEC_GO: begin
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = ST_DEC_WAIT;
      end

      ST_DEC_WAIT: begin
        if (bus.byte_valid) begin
          if (is_text) cnt_seen = cnt_q + 6'd1;
          else         bad_seen = 1'b1;
        end
        cnt_d = cnt_seen;
        bad_d = bad_seen;
        if (bus.dec_done) begin
          if (!bad_seen && (cnt_seen == MSG_DEP_C)) state_d = ST_FOUND;
          else                                      state_d = ST_NEXT_KEY;
        end else if (bus.byte_valid && !is_text) begin
          state_d = ST_ABORT;
        end
      end

      // Decryptor keeps the RAM until it acknowledges the abort with dec_done.
      ST_ABORT: begin
        if (bus.dec_done) state_d = ST_NEXT_KEY;
      end

      ST_NEXT_KEY: begin
        if (key_q == KEY_LAST) begin
          state_d = ST_EXHAUSTED;
        end else begin
          key_d   = key_q + 22'd1;
          state_d = ST_INIT_GO;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so pulses line up with state entry.
  always_comb begin
    init_start_d = (state_d == ST_INIT_GO);
    ksa_start_d  = (state_d == ST_KSA_GO);
    dec_start_d  = (state_d == ST_DEC_GO);
    dec_abort_d  = (state_d == ST_ABORT) && (state_q != ST_ABORT);
    found_d      = (state_d == ST_FOUND);
    exhausted_d  = (state_d == ST_EXHAUSTED);
    busy_d       = 1'b1;
    owner_d      = OWN_NONE;

    case (state_d)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: busy_d = 1'b0;
      default:                         busy_d = 1'b1;
    endcase

    case (state_d)
      ST_INIT_GO, ST_INIT_WAIT:          owner_d = OWN_INIT;
      ST_KSA_GO, ST_KSA_WAIT:            owner_d = OWN_KSA;
      ST_DEC_GO, ST_DEC_WAIT, ST_ABORT:  owner_d = OWN_DEC;
      default:                           owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      key_q        <= KEY_FIRST;
      cnt_q        <= '0;
      bad_q        <= 1'b0;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      dec_abort_q  <= 1'b0;
      owner_q      <= OWN_NONE;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      bad_q        <= bad_d;
      init_start_q <= init_start_d;
      ksa_start_q  <= ksa_start_d;
      dec_start_q  <= dec_start_d;
      dec_abort_q  <= dec_abort_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
    end
  end

  assign bus.init_start = init_start_q;
  assign bus.ksa_start  = ksa_start_q;
  assign bus.dec_start  = dec_start_q;
  assign bus.dec_abort  = dec_abort_q;
  assign bus.mem_owner  = owner_q;
  assign bus.key        = {2'b00, key_q};
  assign bus.busy       = busy_q;
  assign bus.found      = found_q;
  assign bus.exhausted  = exhausted_q;
  assign bus.dbg_state  = state_q;

endmodule
